// File: rtl/regfile_sb.sv
// regfile_sb: integer register file with a per-register scoreboard (busy bits).
//
// After reset the block walks through every register and writes it to zero,
// one register per clock. During that sequence ready is low and the port
// ignores traffic. When the sequence finishes, ready goes high and the
// register file accepts reads, writes and scoreboard allocations.
//
// Ports:
//   clk                 rising-edge clock for all state
//   rst                 synchronous active-high reset (restarts the clear sequence)
//   rs1, rs2            read addresses
//   rs1_data, rs2_data  combinational read data (register 0 always reads 0)
//   rs1_busy, rs2_busy  scoreboard pending flag of the addressed register
//   reg_write, rd,      write port; a write also retires the pending flag
//   rd_data
//   alloc_en, alloc_rd  marks a destination register as pending
//   ready               high once the clear sequence is done
//
// Parameters:
//   XLEN    data width
//   NREGS   register count (power of two, >= 2)
//   BYPASS  1 = same-cycle write data and busy-clear are forwarded to reads

module regfile_sb #(
    parameter int XLEN   = 32,
    parameter int NREGS  = 32,
    parameter bit BYPASS = 1'b1,
    localparam int AW    = $clog2(NREGS)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [AW-1:0]   rs1,
    input  logic [AW-1:0]   rs2,
    output logic [XLEN-1:0] rs1_data,
    output logic [XLEN-1:0] rs2_data,
    output logic            rs1_busy,
    output logic            rs2_busy,
    input  logic            reg_write,
    input  logic [AW-1:0]   rd,
    input  logic [XLEN-1:0] rd_data,
    input  logic            alloc_en,
    input  logic [AW-1:0]   alloc_rd,
    output logic            ready
);

    typedef enum logic {
        CLEAR = 1'b0,
        RUN   = 1'b1
    } state_t;

    localparam logic [AW-1:0] CNT_LAST = AW'(NREGS - 1);
    localparam logic [AW-1:0] CNT_ONE  = AW'(1);

    state_t            state_q, state_d;
    logic [AW-1:0]     cnt_q, cnt_d;
    logic [NREGS-1:0]  busy_q, busy_d;
    logic              ready_q, ready_d;

    // Data storage is deliberately not reset; the clear sequence zeroes it.
    logic [XLEN-1:0]   regs_q [NREGS];

    logic              wr_en;
    logic [AW-1:0]     wr_addr;
    logic [XLEN-1:0]   wr_data;

    logic              run_write;
    logic              run_alloc;

    always_comb begin
        run_write = (state_q == RUN) && reg_write && (rd != '0);
        run_alloc = (state_q == RUN) && alloc_en && (alloc_rd != '0);
    end

    // Next-state, counter, scoreboard and storage write selection.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        busy_d  = busy_q;
        wr_en   = 1'b0;
        wr_addr = cnt_q;
        wr_data = '0;

        if (state_q == CLEAR) begin
            // One register zeroed per cycle; traffic on the port is dropped.
            wr_en   = 1'b1;
            wr_addr = cnt_q;
            wr_data = '0;
            busy_d  = '0;
            cnt_d   = cnt_q + CNT_ONE;
            if (cnt_q == CNT_LAST) begin
                state_d = RUN;
            end
        end else begin
            if (run_write) begin
                wr_en      = 1'b1;
                wr_addr    = rd;
                wr_data    = rd_data;
                busy_d[rd] = 1'b0;
            end
            // Applied after the write so a same-register alloc leaves it pending.
            if (run_alloc) begin
                busy_d[alloc_rd] = 1'b1;
            end
        end
        busy_d[0] = 1'b0;
    end

    always_comb begin
        ready_d = (state_d == RUN);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= CLEAR;
            cnt_q   <= '0;
            busy_q  <= '0;
            ready_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            busy_q  <= busy_d;
            ready_q <= ready_d;
            if (wr_en) begin
                regs_q[wr_addr] <= wr_data;
            end
        end
    end

    assign ready = ready_q;

    // Read ports. A same-cycle write to the addressed register is forwarded
    // when BYPASS is set; its busy-clear is forwarded too unless the same
    // register is being re-allocated in that cycle.
    always_comb begin
        rs1_data = '0;
        rs1_busy = 1'b0;
        if ((state_q == RUN) && (rs1 != '0)) begin
            if (BYPASS && reg_write && (rd == rs1)) begin
                rs1_data = rd_data;
                rs1_busy = (alloc_en && (alloc_rd == rs1)) ? busy_q[rs1] : 1'b0;
            end else begin
                rs1_data = regs_q[rs1];
                rs1_busy = busy_q[rs1];
            end
        end
    end

    always_comb begin
        rs2_data = '0;
        rs2_busy = 1'b0;
        if ((state_q == RUN) && (rs2 != '0)) begin
            if (BYPASS && reg_write && (rd == rs2)) begin
                rs2_data = rd_data;
                rs2_busy = (alloc_en && (alloc_rd == rs2)) ? busy_q[rs2] : 1'b0;
            end else begin
                rs2_data = regs_q[rs2];
                rs2_busy = busy_q[rs2];
            end
        end
    end

endmodule

// File: tb/tb_regfile_sb.sv
// Bench for regfile_sb: two instances (forwarding on and off) share stimulus.
// A behavioural model of the register file is compared against both on every
// falling edge; directed checks pin specific values by hand.

module tb_regfile_sb;

    localparam int XLEN  = 32;
    localparam int NREGS = 32;
    localparam int AW    = 5;

    logic            clk;
    logic            rst;
    logic [AW-1:0]   rs1, rs2, rd, alloc_rd;
    logic            reg_write, alloc_en;
    logic [XLEN-1:0] rd_data;

    logic [XLEN-1:0] b_rs1_data, b_rs2_data, n_rs1_data, n_rs2_data;
    logic            b_rs1_busy, b_rs2_busy, n_rs1_busy, n_rs2_busy;
    logic            b_ready, n_ready;

    int checks = 0;
    int errors = 0;

    regfile_sb #(.XLEN(XLEN), .NREGS(NREGS), .BYPASS(1'b1)) dut (
        .clk(clk), .rst(rst),
        .rs1(rs1), .rs2(rs2),
        .rs1_data(b_rs1_data), .rs2_data(b_rs2_data),
        .rs1_busy(b_rs1_busy), .rs2_busy(b_rs2_busy),
        .reg_write(reg_write), .rd(rd), .rd_data(rd_data),
        .alloc_en(alloc_en), .alloc_rd(alloc_rd),
        .ready(b_ready)
    );

    regfile_sb #(.XLEN(XLEN), .NREGS(NREGS), .BYPASS(1'b0)) dut_nb (
        .clk(clk), .rst(rst),
        .rs1(rs1), .rs2(rs2),
        .rs1_data(n_rs1_data), .rs2_data(n_rs2_data),
        .rs1_busy(n_rs1_busy), .rs2_busy(n_rs2_busy),
        .reg_write(reg_write), .rd(rd), .rd_data(rd_data),
        .alloc_en(alloc_en), .alloc_rd(alloc_rd),
        .ready(n_ready)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%h required=%h at %0t", name, act, req, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    logic [XLEN-1:0] m_reg  [NREGS];
    logic            m_busy [NREGS];
    bit              m_valid = 1'b0;
    bit              m_run   = 1'b0;
    int              m_left  = 0;

    always @(posedge clk) begin
        if (rst) begin
            m_valid = 1'b1;
            m_run   = 1'b0;
            m_left  = NREGS;
            for (int i = 0; i < NREGS; i++) m_busy[i] = 1'b0;
        end else if (m_valid && !m_run) begin
            m_left = m_left - 1;
            if (m_left == 0) begin
                m_run = 1'b1;
                for (int i = 0; i < NREGS; i++) begin
                    m_reg[i]  = '0;
                    m_busy[i] = 1'b0;
                end
            end
        end else if (m_run) begin
            if (reg_write && rd != 0) begin
                m_reg[rd]  = rd_data;
                m_busy[rd] = 1'b0;
            end
            if (alloc_en && alloc_rd != 0) m_busy[alloc_rd] = 1'b1;
        end
    end

    function automatic logic [XLEN-1:0] exp_data(input logic [AW-1:0] rs, input bit byp);
        if (!m_run || rs == 0) return '0;
        if (byp && reg_write && rd == rs) return rd_data;
        return m_reg[rs];
    endfunction

    function automatic logic exp_busy(input logic [AW-1:0] rs, input bit byp);
        if (!m_run || rs == 0) return 1'b0;
        if (byp && reg_write && rd == rs && !(alloc_en && alloc_rd == rs)) return 1'b0;
        return m_busy[rs];
    endfunction

    always @(negedge clk) begin
        if (m_valid) begin
            chk("m_ready_b",    {31'b0, b_ready},    {31'b0, m_run});
            chk("m_ready_nb",   {31'b0, n_ready},    {31'b0, m_run});
            chk("m_rs1_data_b", b_rs1_data, exp_data(rs1, 1'b1));
            chk("m_rs2_data_b", b_rs2_data, exp_data(rs2, 1'b1));
            chk("m_rs1_busy_b", {31'b0, b_rs1_busy}, {31'b0, exp_busy(rs1, 1'b1)});
            chk("m_rs2_busy_b", {31'b0, b_rs2_busy}, {31'b0, exp_busy(rs2, 1'b1)});
            chk("m_rs1_data_nb", n_rs1_data, exp_data(rs1, 1'b0));
            chk("m_rs2_data_nb", n_rs2_data, exp_data(rs2, 1'b0));
            chk("m_rs1_busy_nb", {31'b0, n_rs1_busy}, {31'b0, exp_busy(rs1, 1'b0)});
            chk("m_rs2_busy_nb", {31'b0, n_rs2_busy}, {31'b0, exp_busy(rs2, 1'b0)});
        end
    end

    // ---------------- directed stimulus ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        reg_write = 1'b0; rd = '0; rd_data = '0;
        alloc_en  = 1'b0; alloc_rd = '0;
    endtask

    // Counts cycles with ready low after rst has dropped (bounded).
    task automatic count_clear(output int n);
        n = 0;
        do begin
            tick();
            n++;
        end while (!b_ready && n < 100);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        rst = 1'b1; rs1 = '0; rs2 = '0;
        idle();
        tick(); tick();
        chk("rst_ready", {31'b0, b_ready}, 32'd0);
        chk("rst_data",  b_rs1_data, 32'd0);

        // Initial clear sequence: exactly NREGS cycles of ready low.
        rst = 1'b0;
        count_clear(n);
        chk("clear_len", n, 32'd32);
        for (int i = 0; i < NREGS; i++) begin
            rs1 = AW'(i); rs2 = AW'(NREGS - 1 - i);
            #1;
            chk("clear_zero", b_rs1_data | n_rs2_data, 32'd0);
            chk("clear_busy", {31'b0, b_rs1_busy | n_rs2_busy}, 32'd0);
        end

        // Forwarding vs. no forwarding on register 5.
        reg_write = 1'b1; rd = 5'd5; rd_data = 32'h0000_1111;
        tick();
        rs1 = 5'd5; rs2 = 5'd5; rd_data = 32'hDEAD_BEEF;
        #1;
        chk("byp_rs1", b_rs1_data, 32'hDEAD_BEEF);
        chk("byp_rs2", b_rs2_data, 32'hDEAD_BEEF);
        chk("nobyp_old", n_rs1_data, 32'h0000_1111);
        tick();
        idle();
        #1;
        chk("nobyp_new", n_rs2_data, 32'hDEAD_BEEF);

        // Register 0 ignores writes and allocations.
        reg_write = 1'b1; rd = '0; rd_data = 32'hFFFF_FFFF;
        alloc_en = 1'b1; alloc_rd = '0; rs1 = '0;
        #1;
        chk("r0_byp", b_rs1_data, 32'd0);
        tick();
        idle();
        #1;
        chk("r0_data", b_rs1_data, 32'd0);
        chk("r0_busy", {31'b0, b_rs1_busy}, 32'd0);

        // Allocate 7, then retire it with a write.
        alloc_en = 1'b1; alloc_rd = 5'd7;
        tick();
        idle(); rs2 = 5'd7;
        #1;
        chk("alloc7_busy", {31'b0, b_rs2_busy}, 32'd1);
        reg_write = 1'b1; rd = 5'd7; rd_data = 32'h12;
        #1;
        chk("wr7_busy_byp",   {31'b0, b_rs2_busy}, 32'd0);
        chk("wr7_busy_nobyp", {31'b0, n_rs2_busy}, 32'd1);
        tick();
        idle();
        #1;
        chk("wr7_data", n_rs2_data, 32'h12);
        chk("wr7_busy", {31'b0, n_rs2_busy}, 32'd0);

        // Same-register alloc and write: data lands, busy stays set.
        reg_write = 1'b1; rd = 5'd9; rd_data = 32'h55;
        alloc_en = 1'b1; alloc_rd = 5'd9;
        tick();
        idle(); rs1 = 5'd9;
        #1;
        chk("aw9_data", b_rs1_data, 32'h55);
        chk("aw9_busy", {31'b0, b_rs1_busy}, 32'd1);

        // Different-register alloc and write both apply.
        reg_write = 1'b1; rd = 5'd4; rd_data = 32'hAB;
        alloc_en = 1'b1; alloc_rd = 5'd3;
        tick();
        idle(); rs1 = 5'd3; rs2 = 5'd4;
        #1;
        chk("diff_busy3", {31'b0, b_rs1_busy}, 32'd1);
        chk("diff_data4", b_rs2_data, 32'hAB);
        chk("diff_busy4", {31'b0, b_rs2_busy}, 32'd0);

        // Mixed traffic covered by the model.
        for (int k = 0; k < 24; k++) begin
            reg_write = (k % 4) != 3;
            rd        = AW'((k * 3) % NREGS);
            rd_data   = 32'hA500_0000 + k;
            alloc_en  = (k % 2) == 0;
            alloc_rd  = AW'((k * 7) % NREGS);
            rs1       = AW'((k * 3) % NREGS);
            rs2       = AW'((k % 3 == 0) ? (k * 7) % NREGS : (k * 5) % NREGS);
            tick();
        end
        idle();

        // Fill every register, then reset in the middle of the clear.
        for (int i = 1; i < NREGS; i++) begin
            reg_write = 1'b1; rd = AW'(i); rd_data = 32'h0101_0101 * i;
            tick();
        end
        idle(); rs1 = 5'd20;
        #1;
        chk("fill20", b_rs1_data, 32'h1414_1414);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        repeat (10) tick();
        rst = 1'b1; reg_write = 1'b1; rd = 5'd20; rd_data = 32'hCAFE_F00D;
        tick();
        chk("midrst_ready", {31'b0, b_ready}, 32'd0);
        rst = 1'b0; rd = 5'd3; rd_data = 32'h77;
        alloc_en = 1'b1; alloc_rd = 5'd6;
        count_clear(n);
        idle();
        chk("midrst_len", n, 32'd32);
        for (int i = 0; i < NREGS; i++) begin
            rs1 = AW'(i); rs2 = AW'(i);
            #1;
            chk("midrst_zero", n_rs1_data, 32'd0);
            chk("midrst_busy", {31'b0, b_rs2_busy}, 32'd0);
        end
        tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/regfile_sb.md
REGFILE_SB -- requirements
Module: regfile_sb

Interface
REQ-001 Parameter: XLEN, 32, data width in bits.
REQ-002 Parameter: NREGS, 32, register count, power of two, minimum 2; register 0 hardwired to zero.
REQ-003 Parameter: BYPASS, 1, 1 = write-to-read forwarding enabled; 0 = reads return stored value only.
REQ-004 Derived: AW = clog2(NREGS).
REQ-005 One clock; reset is synchronous and active-high; ports clk, rst.
REQ-006 clk  input  1  rising-edge clock for all state.
REQ-007 rst  input  1  synchronous active-high reset.
REQ-008 rs1, rs2  input  AW each  read addresses.
REQ-009 rs1_data, rs2_data  output  XLEN each  read data.
REQ-010 rs1_busy, rs2_busy  output  1 each  scoreboard pending flag of addressed register.
REQ-011 reg_write  input  1  write enable.
REQ-012 rd  input  AW  write address.
REQ-013 rd_data  input  XLEN  write data.
REQ-014 alloc_en  input  1  mark destination pending (issue of a producer).
REQ-015 alloc_rd  input  AW  register to mark pending.
REQ-016 ready  output  1  high when clear sequence is done and the port accepts traffic.

Function
REQ-017 States: CLEAR, RUN; rst forces CLEAR with clear counter = 0 on the next edge, from any state, including mid-clear.
REQ-018 CLEAR: one register per cycle is written to zero at counter address; counter increments; after address NREGS-1 is cleared, next state is RUN; clear takes exactly NREGS cycles after rst deasserts.
REQ-019 CLEAR: ready = 0, rs1_data = rs2_data = 0, rs*_busy = 0; reg_write and alloc_en ignored; all busy bits held at 0.
REQ-020 RUN: ready = 1.
REQ-021 Write: at clk edge in RUN, if reg_write and rd != 0, reg[rd] <= rd_data and busy[rd] <= 0.
REQ-022 Write with rd = 0: no state change.
REQ-023 Read: combinational; rsN_data = reg[rsN]; rsN = 0 always returns 0.
REQ-024 Bypass (BYPASS = 1, RUN): if reg_write and rd = rsN and rd != 0, rsN_data = rd_data in same cycle; applies independently to both ports, including rs1 = rs2 = rd.
REQ-025 BYPASS = 0: write visible on read the cycle after the edge.
REQ-026 Alloc: at clk edge in RUN, if alloc_en and alloc_rd != 0, busy[alloc_rd] <= 1; alloc_rd = 0 ignored.
REQ-027 Simultaneous alloc and write to same register: data written, busy ends 1 (alloc wins).
REQ-028 Simultaneous alloc and write to different registers: both take effect.
REQ-029 rsN_busy = busy[rsN]; with BYPASS = 1 and a same-cycle write to rsN (not re-allocated), rsN_busy = 0.
REQ-030 busy[0] constant 0.
REQ-031 No out-of-range addresses possible (NREGS = 2^AW).

Reset
REQ-032 During rst high: ready = 0, state CLEAR, counter = 0, all busy = 0, rs*_data = 0.
REQ-033 After NREGS clear cycles, every register reads 0 and no register is busy.
REQ-034 Register contents at first rst edge are don't-care; no initial-value dependence permitted.

Verification
REQ-035 rst 1 cycle, NREGS=32 -> ready low exactly 32 cycles, then high; rs1 = 0..31 all read 0, busy 0.
REQ-036 RUN, write rd=5 0xDEADBEEF with rs1=rs2=5, BYPASS=1 -> both ports read 0xDEADBEEF same cycle; BYPASS=0 -> old value same cycle, 0xDEADBEEF next cycle.
REQ-037 Write rd=0 0xFFFFFFFF, alloc_rd=0 -> rs1=0 reads 0, rs1_busy 0.
REQ-038 alloc rd=7; next cycle rs2=7 -> rs2_busy 1; write rd=7 0x12 -> rs2_busy 0 same cycle (BYPASS=1), next cycle data 0x12, busy 0.
REQ-039 Same-cycle alloc and write rd=9 0x55 -> next cycle reg 9 = 0x55, busy 1.
REQ-040 Fill regs, rst asserted at clear counter = 10 -> counter restarts at 0, ready low a full NREGS cycles after rst drops, writes during clear dropped.
